// File: rtl/audio_pkg.sv
// Shared audio stream types and constants for the tone-generator to codec path.
package audio_pkg;

  localparam int CLK_FREQ        = 50_000_000;
  localparam int I2S_SAMPLE_BITS = 16;

  typedef logic [I2S_SAMPLE_BITS-1:0] sample_t;

  // Bit carried in channel slot p: slots 1..16 hold the sample MSB first, everything else is 0.
  function automatic logic sample_bit(sample_t smp, int p);
    sample_t w_shift;
    if (p < 1 || p > I2S_SAMPLE_BITS) return 1'b0;
    w_shift = smp << (p - 1);
    return w_shift[I2S_SAMPLE_BITS-1];
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous sample FIFO with registered full/empty/level flags.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_level_nxt;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) w_level_nxt = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_nxt = r_level - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == '0);
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_MAX) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_MAX) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // Storage is data only; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/i2s_sample_serializer.sv
// I2S master: buffers mono samples and sends each one, duplicated on L and R, as one I2S frame.
module i2s_sample_serializer
  import audio_pkg::*;
#(
  parameter int BCLK_HALF  = 8,
  parameter int CH_BITS    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 sample,
  input  logic                        sample_valid,
  output logic                        sink_ready,
  input  logic                        enable,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_dacdat,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int HC_W = $clog2(BCLK_HALF);
  localparam int S_W  = $clog2(2 * CH_BITS);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(BCLK_HALF - 1);
  localparam logic [S_W-1:0]  S_MAX  = S_W'(2 * CH_BITS - 1);
  localparam logic [S_W-1:0]  S_CH   = S_W'(CH_BITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]      r_state;
  logic [HC_W-1:0] r_hc;
  logic [S_W-1:0]  r_s;
  logic            r_bclk;
  logic            r_lrclk;
  logic            r_dacdat;
  logic            r_underrun;
  logic            r_rst_done;
  sample_t         r_hold;

  logic            w_fifo_full;
  logic            w_fifo_empty;
  sample_t         w_fifo_rdata;
  logic            w_push;
  logic            w_pop;
  logic            w_hc_wrap;
  logic            w_slot_edge;
  logic            w_frame_end;
  logic            w_start;
  logic [S_W-1:0]  w_s_nxt;

  // Serial bit for slot s; both channels reuse the same hold word.
  function automatic logic slot_data(sample_t h, logic [S_W-1:0] s);
    int p;
    p = int'(s);
    if (p >= CH_BITS) p = p - CH_BITS;
    return sample_bit(h, p);
  endfunction

  sample_fifo #(
    .WIDTH(I2S_SAMPLE_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (sample),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  assign sink_ready = r_rst_done && !w_fifo_full;
  assign w_push     = sample_valid && sink_ready;

  assign w_hc_wrap   = (r_hc == HC_MAX);
  assign w_slot_edge = (r_state == ST_RUN) && w_hc_wrap && r_bclk;
  assign w_frame_end = w_slot_edge && (r_s == S_MAX);
  assign w_s_nxt     = (r_s == S_MAX) ? '0 : r_s + 1'b1;
  // Frame start: leaving IDLE, or a frame end while still enabled (DRAIN never pops).
  assign w_start     = ((r_state == ST_IDLE) && enable) || (w_frame_end && enable);
  assign w_pop       = w_start && !w_fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hc       <= '0;
      r_s        <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_dacdat   <= 1'b0;
      r_underrun <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      r_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_hc     <= '0;
          r_s      <= '0;
          r_bclk   <= 1'b0;
          r_lrclk  <= 1'b0;
          r_dacdat <= 1'b0;
          if (enable) begin
            r_state    <= ST_RUN;
            r_underrun <= w_fifo_empty;
          end
        end
        ST_RUN: begin
          r_hc <= w_hc_wrap ? '0 : r_hc + 1'b1;
          if (w_hc_wrap) r_bclk <= ~r_bclk;
          if (w_slot_edge) begin
            r_s      <= w_s_nxt;
            r_lrclk  <= (w_s_nxt >= S_CH);
            r_dacdat <= slot_data(r_hold, w_s_nxt);
            if (w_frame_end) begin
              if (!enable) r_state <= ST_DRAIN;
              else r_underrun <= w_fifo_empty;
            end
          end
        end
        ST_DRAIN: begin
          r_bclk   <= 1'b0;
          r_lrclk  <= 1'b0;
          r_dacdat <= 1'b0;
          if (w_hc_wrap) begin
            r_hc    <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // An empty FIFO at frame start sends silence.
  always_ff @(posedge clk) begin
    if (w_start) r_hold <= w_fifo_empty ? '0 : w_fifo_rdata;
  end

  assign i2s_bclk   = r_bclk;
  assign i2s_lrclk  = r_lrclk;
  assign i2s_dacdat = r_dacdat;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_i2s_sample_serializer.sv
// Scoreboard bench for i2s_sample_serializer: frames are deserialized on rising BCLK and
// compared against the samples the bench pushed, in order, with silence on underrun.
module tb_i2s_sample_serializer;

  localparam int BCLK_HALF = 8;
  localparam int CH_BITS   = 32;
  localparam int FIFO_D    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample;
  logic        sample_valid;
  logic        sink_ready;
  logic        enable;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_dacdat;
  logic        underrun;
  logic [2:0]  fifo_level;

  i2s_sample_serializer #(
    .BCLK_HALF (BCLK_HALF),
    .CH_BITS   (CH_BITS),
    .FIFO_DEPTH(FIFO_D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sink_ready  (sink_ready),
    .enable      (enable),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_dacdat  (i2s_dacdat),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: accepted samples in order, and expected frame payloads.
  logic [15:0] exp_q[$];
  logic [15:0] exp_frames[$];

  int          k = 0;
  int          push_total = 0;
  int          pops = 0;
  bit          pend = 0;
  int          hist_push[16];
  bit          hist_und[16];
  int          und_seen = 0;
  int          und_exp = 0;
  int          glitches = 0;
  int          frames_checked = 0;
  int          slot = 0;
  int          last_rise = 0;
  bit          bad_period = 0;
  int          low_run = 0;
  bit          lr_valid = 0;
  int          lr_last = 0;
  bit          prev_bclk = 0, prev_lr = 0, prev_dat = 0;
  logic [63:0] fbits, flr;
  logic [15:0] exp_s;
  int          f_idx, occ;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_frames.delete();
      push_total = 0; pops = 0; pend = 0; slot = 0; bad_period = 0;
      lr_valid = 0; low_run = 0;
      prev_bclk = 0; prev_lr = 0; prev_dat = 0;
    end else begin
      k++;
      hist_push[k % 16] = push_total;
      if (pend) push_total++;
      pend = sample_valid && sink_ready;
      hist_und[k % 16] = underrun;
      if (underrun) und_seen++;
      if (!(prev_bclk && !i2s_bclk) && ((i2s_dacdat != prev_dat) || (i2s_lrclk != prev_lr)))
        glitches++;

      if (i2s_bclk) low_run = 0;
      else low_run++;
      if (low_run > BCLK_HALF) lr_valid = 0;

      if (!prev_lr && i2s_lrclk) begin
        if (lr_valid) chk("lrclk_period", 64'(k - lr_last), 64'd1024);
        lr_last = k;
        lr_valid = 1;
      end

      if (!prev_bclk && i2s_bclk) begin
        if (slot == 0) begin
          // The frame started half a BCLK period before its first rising edge.
          f_idx = (k - BCLK_HALF) % 16;
          occ = hist_push[f_idx] - pops;
          chk("underrun_at_frame_start", 64'(hist_und[f_idx]), 64'(occ == 0));
          if (occ > 0) begin
            chk("model_has_sample", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) exp_frames.push_back(exp_q.pop_front());
            else exp_frames.push_back(16'h0);
            pops++;
          end else begin
            exp_frames.push_back(16'h0);
            und_exp++;
          end
          bad_period = 0;
        end else if (k - last_rise != 2 * BCLK_HALF) begin
          bad_period = 1;
        end
        last_rise = k;
        fbits[63 - slot] = i2s_dacdat;
        flr[63 - slot]   = i2s_lrclk;
        slot++;
        if (slot == 2 * CH_BITS) begin
          slot = 0;
          frames_checked++;
          chk("frame_expected", 64'(exp_frames.size() > 0), 64'd1);
          exp_s = (exp_frames.size() > 0) ? exp_frames.pop_front() : 16'h0;
          // Per channel: slot 0 empty, slots 1..16 sample MSB first, slots 17..31 zero.
          chk("frame_data", fbits, {1'b0, exp_s, 15'h0, 1'b0, exp_s, 15'h0});
          chk("frame_lrclk", flr, {32'h0, 32'hFFFF_FFFF});
          chk("bclk_period_ok", 64'(bad_period), 64'd0);
        end
      end
      prev_bclk = i2s_bclk;
      prev_lr   = i2s_lrclk;
      prev_dat  = i2s_dacdat;
    end
  end

  task automatic push_sample(input logic [15:0] d, input int max_wait, output bit ok);
    bit acc;
    ok = 0;
    sample = d;
    sample_valid = 1'b1;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      acc = sink_ready;
      if (acc) exp_q.push_back(d);
      @(posedge clk); #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_und(input int target, input int budget, input string name);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (und_seen >= target) begin
        done = 1;
        break;
      end
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  bit ok;
  bit done;
  int gap;

  initial begin
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_i2s_outputs", {i2s_bclk, i2s_lrclk, i2s_dacdat, underrun}, 4'h0);
    chk("reset_sink_ready", sink_ready, 1'b0);
    chk("reset_level", fifo_level, 3'd0);
    #2 reset = 1'b0;
    #1 chk("ready_low_before_edge", sink_ready, 1'b0);
    @(posedge clk); #1;
    chk("ready_after_release", sink_ready, 1'b1);
    chk("level_after_release", fifo_level, 3'd0);
    chk("idle_i2s_outputs", {i2s_bclk, i2s_lrclk, i2s_dacdat, underrun}, 4'h0);

    // Fill the FIFO while disabled.
    push_sample(16'hA5C3, 10, ok);
    chk("push_first", ok, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push_sample(16'($urandom), 10, ok);
      chk("push_fill", ok, 1'b1);
      if (i == 1) begin
        chk("ready_at_3", sink_ready, 1'b1);
        chk("level_at_3", fifo_level, 3'd3);
      end
    end
    chk("ready_when_full", sink_ready, 1'b0);
    chk("level_when_full", fifo_level, 3'd4);
    push_sample(16'($urandom), 20, ok);
    chk("fifth_held_off", ok, 1'b0);
    chk("level_still_full", fifo_level, 3'd4);
    chk("idle_bclk_while_disabled", i2s_bclk, 1'b0);

    // Four queued frames, then silent frames with one underrun each.
    enable = 1'b1;
    wait_und(und_seen + 3, 9000, "underruns_after_drain");

    for (int n = 0; n < 12; n++) begin
      gap = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(200, 2500));
      wait_cycles(gap);
      push_sample(16'($urandom), 4000, ok);
      chk("random_push", ok, 1'b1);
    end

    // Disable mid-frame with two samples queued.
    wait_und(und_seen + 1, 8000, "underrun_before_disable");
    wait_cycles(100);
    push_sample(16'($urandom), 10, ok);
    chk("queue_a", ok, 1'b1);
    push_sample(16'($urandom), 10, ok);
    chk("queue_b", ok, 1'b1);
    chk("level_two_queued", fifo_level, 3'd2);
    wait_cycles(200);
    enable = 1'b0;
    done = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (low_run > 4 * BCLK_HALF) begin
        done = 1;
        break;
      end
    end
    chk("reached_idle", done, 1'b1);
    chk("level_kept_in_idle", fifo_level, 3'd2);
    chk("idle_outputs_after_drain", {i2s_bclk, i2s_lrclk, i2s_dacdat}, 3'h0);

    // Queued samples go out once re-enabled.
    enable = 1'b1;
    wait_und(und_seen + 1, 4000, "underrun_after_reenable");
    push_sample(16'($urandom), 10, ok);
    chk("pre_reset_push_a", ok, 1'b1);
    push_sample(16'($urandom), 10, ok);
    chk("pre_reset_push_b", ok, 1'b1);

    // Reset at slot 20 of a running frame.
    done = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (slot == 21 && i2s_bclk) begin
        done = 1;
        break;
      end
    end
    chk("reached_slot20", done, 1'b1);
    chk("bclk_high_at_slot20", i2s_bclk, 1'b1);
    #2 reset = 1'b1; enable = 1'b0;
    #1;
    chk("async_reset_i2s", {i2s_bclk, i2s_lrclk, i2s_dacdat, underrun}, 4'h0);
    chk("async_reset_ready", sink_ready, 1'b0);
    chk("async_reset_level", fifo_level, 3'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("level_after_midframe_reset", fifo_level, 3'd0);
    chk("ready_after_midframe_reset", sink_ready, 1'b1);
    wait_cycles(50);
    chk("idle_after_midframe_reset", {i2s_bclk, i2s_lrclk, i2s_dacdat, underrun}, 4'h0);

    chk("underrun_pulse_count", 64'(und_seen), 64'(und_exp));
    chk("changes_off_slot_edge", 64'(glitches), 64'd0);
    chk("enough_frames", 64'(frames_checked >= 20), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
